// File: rtl/out_frame_packer_if.sv
// Byte-stream interface for out_frame_packer: upstream sample input,
// framed valid/ready output and status counters.
interface out_frame_packer_if #(
    parameter int DEPTH = 16
) ();
    logic [7:0]                 in_byte;
    logic                       in_valid;
    logic [7:0]                 out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       frame_done;
    logic [7:0]                 drop_cnt;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    // Packer side
    modport master (
        input  in_byte, in_valid, out_ready,
        output out_data, out_valid, out_last, frame_done, drop_cnt, fifo_count
    );

    // Source/sink side
    modport slave (
        output in_byte, in_valid, out_ready,
        input  out_data, out_valid, out_last, frame_done, drop_cnt, fifo_count
    );
endinterface

// File: rtl/out_frame_packer.sv
// Buffers upstream sample bytes in a FIFO and emits FRAME_LEN payload
// bytes followed by a mod-256 checksum byte over a valid/ready link.
// Bytes arriving while the FIFO is full (and not popping) are dropped
// and counted in a saturating counter.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no output; wait until a full frame is buffered
// S_PAYLOAD | presenting FIFO head; beats_left counts down to last byte
// S_CHKSUM  | presenting checksum byte with out_last
module out_frame_packer #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    out_frame_packer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHKSUM
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      checksum_q, checksum_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [BW-1:0]   beats_left_q, beats_left_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      mem_q [DEPTH];

    logic            xfer;
    logic            push;
    logic            pop;
    logic            full;
    logic            out_valid_c;
    logic            out_last_c;
    logic [7:0]      out_data_c;

    // FIFO bookkeeping: push/pop decisions, pointers, occupancy, drop counter
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        xfer       = (state_q != S_IDLE) && bus.out_ready;
        pop        = xfer && (state_q == S_PAYLOAD);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push       = bus.in_valid && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        drop_cnt_d = drop_cnt_q;
        if (bus.in_valid && !push && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Frame FSM: next state, checksum accumulation, beat countdown, outputs
    always_comb begin
        state_d      = state_q;
        checksum_d   = checksum_q;
        beats_left_d = beats_left_q;
        frame_done_d = 1'b0;
        out_valid_c  = 1'b0;
        out_last_c   = 1'b0;
        out_data_c   = 8'h00;
        case (state_q)
            S_IDLE: begin
                checksum_d   = 8'h00;
                beats_left_d = BW'(FRAME_LEN - 1);
                if (count_q >= CW'(FRAME_LEN)) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                out_valid_c = 1'b1;
                out_data_c  = mem_q[rd_ptr_q];
                if (xfer) begin
                    checksum_d = checksum_q + out_data_c;
                    if (beats_left_q == '0) begin
                        state_d = S_CHKSUM;
                    end else begin
                        beats_left_d = beats_left_q - BW'(1);
                    end
                end
            end
            S_CHKSUM: begin
                out_valid_c = 1'b1;
                out_last_c  = 1'b1;
                out_data_c  = checksum_q;
                if (xfer) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            checksum_q   <= 8'h00;
            drop_cnt_q   <= 8'h00;
            beats_left_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            checksum_q   <= checksum_d;
            drop_cnt_q   <= drop_cnt_d;
            beats_left_q <= beats_left_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.in_byte;
        end
    end

    assign bus.out_valid  = out_valid_c;
    assign bus.out_last   = out_last_c;
    assign bus.out_data   = out_data_c;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_out_frame_packer.sv
// Bench for out_frame_packer: directed scenarios with literal expectations
// plus a randomized phase, all checked each cycle against a queue-based model.
module tb_out_frame_packer;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    out_frame_packer_if #(.DEPTH(DEPTH)) bus ();

    out_frame_packer #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos: -1 idle, 0..FRAME_LEN-1 payload beat, FRAME_LEN checksum beat
    logic [7:0] m_fifo[$];
    logic [7:0] m_frame[$];
    int         m_pos   = -1;
    int         m_drops = 0;
    bit         m_done  = 1'b0;
    bit         m_xf, m_pp;
    int         m_sz;

    function automatic logic [7:0] frame_sum();
        int s = 0;
        foreach (m_frame[i]) s += int'(m_frame[i]);
        return 8'(s % 256);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_frame.delete();
            m_pos   = -1;
            m_drops = 0;
            m_done  = 1'b0;
        end else begin
            m_sz   = m_fifo.size();
            m_xf   = (m_pos >= 0) && bus.out_ready;
            m_pp   = m_xf && (m_pos < FRAME_LEN);
            m_done = m_xf && (m_pos == FRAME_LEN);
            if (m_pos < 0) begin
                if (m_sz >= FRAME_LEN) begin
                    m_pos = 0;
                    m_frame.delete();
                end
            end else if (m_xf) begin
                if (m_pos < FRAME_LEN) begin
                    m_frame.push_back(m_fifo[0]);
                    m_pos++;
                end else begin
                    m_pos = -1;
                end
            end
            if (m_pp) void'(m_fifo.pop_front());
            if (bus.in_valid) begin
                if (m_sz < DEPTH || m_pp) m_fifo.push_back(bus.in_byte);
                else m_drops++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", bus.out_valid, (m_pos >= 0));
            check("out_last", bus.out_last, (m_pos == FRAME_LEN));
            if (m_pos >= 0)
                check("out_data", bus.out_data,
                      (m_pos < FRAME_LEN) ? m_fifo[0] : frame_sum());
            check("frame_done", bus.frame_done, m_done);
            check("fifo_count", bus.fifo_count, m_fifo.size());
            check("drop_cnt", bus.drop_cnt, (m_drops > 255) ? 255 : m_drops);
        end
    end

    // Log of every completed transfer: {out_last, out_data}
    logic [8:0] xlog[$];
    always @(posedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            xlog.push_back({bus.out_last, bus.out_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int lim, input string nm);
        int k = 0;
        while (xlog.size() < n && k < lim) begin
            cyc();
            k++;
        end
        check(nm, xlog.size(), n);
    endtask

    task automatic check_frame(input int base, input logic [8:0] exp[5], input string nm);
        for (int i = 0; i < 5; i++) begin
            if (base + i < xlog.size()) check(nm, xlog[base+i], exp[i]);
            else check({nm, "_missing"}, xlog.size(), base + 5);
        end
    endtask

    int         base;
    logic [7:0] held;
    logic [8:0] exp2[5] = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h10A};
    logic [8:0] exp3[5] = '{9'h0FF, 9'h0FF, 9'h001, 9'h002, 9'h101};
    logic [8:0] exp4[5] = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h18A};
    logic [8:0] exp6[5] = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h106};

    initial begin
        // 1: reset with in_valid asserted
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        bus.out_ready = 1'b0;
        repeat (2) cyc();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_out_data", bus.out_data, 8'h00);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk_en       = 1'b1;

        // 2: basic frame and latency
        bus.out_ready = 1'b1;
        base = xlog.size();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        check("lat_t1_valid", bus.out_valid, 0);
        cyc();
        check("lat_t2_valid", bus.out_valid, 1);
        check("lat_t2_data", bus.out_data, 8'h01);
        wait_log(base + 5, 20, "t2_timeout");
        check("t2_frame_done", bus.frame_done, 1);
        check_frame(base, exp2, "t2_frame");
        cyc();
        check("t2_frame_done_pulse", bus.frame_done, 0);

        // 3: checksum wrap
        base = xlog.size();
        push(8'hFF); push(8'hFF); push(8'h01); push(8'h02);
        wait_log(base + 5, 20, "t3_timeout");
        check_frame(base, exp3, "t3_frame");

        // 4: backpressure mid-frame
        repeat (2) cyc();
        base = xlog.size();
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        wait_log(base + 2, 20, "t4_pre_timeout");
        bus.out_ready = 1'b0;
        held = bus.out_data;
        check("t4_head", held, 8'hA3);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t4_stall_data", bus.out_data, held);
            check("t4_stall_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        wait_log(base + 5, 20, "t4_timeout");
        check_frame(base, exp4, "t4_frame");

        // 5: overflow, order retention, saturation
        repeat (2) cyc();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(8'(8'h30 + i));
        check("t5_fifo_count", bus.fifo_count, 16);
        check("t5_drop_cnt", bus.drop_cnt, 4);
        bus.out_ready = 1'b1;
        base = xlog.size();
        wait_log(base + 20, 200, "t5_timeout");
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < 4; b++)
                if (base + f*5 + b < xlog.size())
                    check("t5_payload", xlog[base+f*5+b][7:0], 8'(8'h30 + f*4 + b));
        bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) push(8'($urandom));
        check("t5_drop_sat", bus.drop_cnt, 8'hFF);

        // 6: reset mid-frame after two payload transfers
        bus.out_ready = 1'b1;
        base = xlog.size();
        wait_log(base + 2, 20, "t6_pre_timeout");
        rst = 1'b1;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_fifo_count", bus.fifo_count, 0);
        check("t6_drop_cnt", bus.drop_cnt, 0);
        bus.out_ready = 1'b1;
        base = xlog.size();
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        wait_log(base + 5, 20, "t6_timeout");
        check_frame(base, exp6, "t6_frame");

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_byte   = 8'($urandom);
            bus.out_ready = ($urandom_range(2) != 0);
            rst           = ($urandom_range(599) == 0);
            cyc();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
